// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with fill-level status flags, sticky error flags
// and a selectable standard or first-word-fall-through read port.
module sync_fifo_ctrl #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                rinc,
    input  logic                clr_err,
    output logic [DATASIZE-1:0] rdata,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH_C  = DEPTH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AFULL_C  = AFULL_THRESH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AEMPTY_C = AEMPTY_THRESH[ADDRSIZE:0];

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE-1:0] wptr;
    logic [ADDRSIZE-1:0] rptr;
    logic                wr_ok;
    logic                rd_ok;

    assign empty        = (count == '0);
    assign full         = (count == DEPTH_C);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_ok = winc & ~full;
    assign rd_ok = rinc & ~empty;

    // Storage is intentionally unreset; pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Error set takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rinc && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic [DATASIZE-1:0] hold_q;

            // hold_q remembers the last word shown so rdata stays stable while empty.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_q <= '0;
                end else if (!empty) begin
                    hold_q <= mem[rptr];
                end
            end

            assign rdata = empty ? hold_q : mem[rptr];
        end else begin : g_std
            logic [DATASIZE-1:0] rdata_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rd_ok) begin
                    rdata_q <= mem[rptr];
                end
            end

            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: vector table plus queue-based reference
// model for the standard read port, and a short sequence on a FWFT instance.
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFT   = 14;
    localparam int AET   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          winc, rinc, clr_err;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    logic          winc2, rinc2, clr_err2;
    logic [DW-1:0] wdata2;
    logic [DW-1:0] rdata2;
    logic          full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;
    logic [AW:0]   count2;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(AFT),
                     .AEMPTY_THRESH(AET), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .clr_err(clr_err), .rdata(rdata), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .AFULL_THRESH(AFT),
                     .AEMPTY_THRESH(AET), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .winc(winc2), .wdata(wdata2), .rinc(rinc2),
        .clr_err(clr_err2), .rdata(rdata2), .full(full2), .empty(empty2),
        .almost_full(almost_full2), .almost_empty(almost_empty2), .count(count2),
        .overflow(overflow2), .underflow(underflow2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf, m_unf;
    logic [DW-1:0] m_rdata;

    typedef struct {
        logic          w;
        logic [DW-1:0] wd;
        logic          r;
        logic          c;
        int            e_count;
        logic          e_empty;
        logic          e_aempty;
        logic          e_unf;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
    endtask

    task automatic check_state(input string tag);
        int c;
        c = mq.size();
        chk({tag, ":count"}, 32'(count), 32'(c));
        chk({tag, ":flags{full,empty,af,ae}"}, {28'd0, full, empty, almost_full, almost_empty},
            {28'd0, c == DEPTH, c == 0, c >= AFT, c <= AET});
        chk({tag, ":err{ovf,unf}"}, {30'd0, overflow, underflow}, {30'd0, m_ovf, m_unf});
        chk({tag, ":rdata"}, 32'(rdata), 32'(m_rdata));
    endtask

    // One clock of stimulus on the standard-read instance, checked against the model.
    task automatic cycle(input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
        int  cnt;
        logic w_ok, r_ok;
        winc = w; wdata = wd; rinc = r; clr_err = c;
        cnt  = mq.size();
        w_ok = w && (cnt < DEPTH);
        r_ok = r && (cnt > 0);
        if (r_ok) exp_q.push_back(mq.pop_front());
        if (w_ok) mq.push_back(wd);
        if (w && cnt == DEPTH) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && cnt == 0)     m_unf = 1'b1; else if (c) m_unf = 1'b0;
        @(posedge clk);
        #1;
        if (r_ok) m_rdata = exp_q.pop_front();
        check_state("cyc");
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ":count"}, 32'(count), 32'd0);
        chk({tag, ":flags{full,empty,af,ae}"}, {28'd0, full, empty, almost_full, almost_empty},
            32'b0101);
        chk({tag, ":err{ovf,unf}"}, {30'd0, overflow, underflow}, 32'd0);
        chk({tag, ":rdata"}, 32'(rdata), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;

        vecs[0]  = '{1'b1, 8'd10, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'd15, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 8'd20, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 8'd25, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 8'd30, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 8'd35, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 8'd40, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 8'd0,  1'b1, 1'b0, 6, 1'b0, 1'b0, 1'b0, 8'd10};
        vecs[8]  = '{1'b0, 8'd0,  1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b0, 8'd15};
        vecs[9]  = '{1'b0, 8'd0,  1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 8'd20};
        vecs[10] = '{1'b0, 8'd0,  1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'd25};
        vecs[11] = '{1'b0, 8'd0,  1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 8'd30};
        vecs[12] = '{1'b0, 8'd0,  1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 8'd35};
        vecs[13] = '{1'b0, 8'd0,  1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'd40};
        vecs[14] = '{1'b0, 8'd0,  1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b1, 8'd40};
        vecs[15] = '{1'b0, 8'd0,  1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'd40};

        rst = 1'b1;
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
        winc2 = 1'b0; rinc2 = 1'b0; clr_err2 = 1'b0; wdata2 = '0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        chk("reset:fwft_rdata", 32'(rdata2), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Vector table: fill 7, drain 7, underflow, clear
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].w, vecs[i].wd, vecs[i].r, vecs[i].c);
            chk($sformatf("vec%0d:count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d:empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d:aempty", i), 32'(almost_empty), 32'(vecs[i].e_aempty));
            chk($sformatf("vec%0d:underflow", i), 32'(underflow), 32'(vecs[i].e_unf));
            chk($sformatf("vec%0d:rdata", i), 32'(rdata), 32'(vecs[i].e_rdata));
        end

        // Fill to full, overflow attempt, simultaneous read+write at full
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(i * 7 + 3), 1'b0, 1'b0);
            if (i == AFT - 2) chk("fill:af_below", 32'(almost_full), 32'd0);
            if (i == AFT - 1) chk("fill:af_at", 32'(almost_full), 32'd1);
        end
        chk("fill:full", 32'(full), 32'd1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("ovf:count", 32'(count), 32'd16);
        chk("ovf:flag", 32'(overflow), 32'd1);
        cycle(1'b1, 8'hDD, 1'b1, 1'b0);
        chk("full_rw:count", 32'(count), 32'd15);
        chk("full_rw:full", 32'(full), 32'd0);
        chk("full_rw:rdata", 32'(rdata), 32'd3);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("mid:count9", 32'(count), 32'd9);

        // Asynchronous reset mid-stream, requests held during reset
        #2;
        rst = 1'b1; winc = 1'b1; wdata = 8'h77; rinc = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk("midrst:req_ignored", 32'(count), 32'd0);
        winc = 1'b0; rinc = 1'b0;
        rst = 1'b0;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("postrst:first_word", 32'(rdata), 32'h3C);

        // Empty with simultaneous read+write
        cycle(1'b1, 8'h42, 1'b1, 1'b0);
        chk("empty_rw:count", 32'(count), 32'd1);
        chk("empty_rw:unf", 32'(underflow), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("clr:unf", 32'(underflow), 32'd0);

        // Steady streaming with wrap
        for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom_range(0, 63)), 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            d = DW'($urandom_range(0, 63));
            cycle(1'b1, d, 1'b1, 1'b0);
        end
        chk("stream:count", 32'(count), 32'd7);
        for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("stream:empty", 32'(empty), 32'd1);

        // First-word-fall-through instance
        winc2 = 1'b1; wdata2 = 8'hA5;
        @(posedge clk);
        #1;
        winc2 = 1'b0;
        chk("fwft:empty", 32'(empty2), 32'd0);
        chk("fwft:rdata", 32'(rdata2), 32'hA5);
        winc2 = 1'b1; wdata2 = 8'h5A;
        @(posedge clk);
        #1;
        winc2 = 1'b0;
        chk("fwft:head_stable", 32'(rdata2), 32'hA5);
        rinc2 = 1'b1;
        @(posedge clk);
        #1;
        chk("fwft:advance", 32'(rdata2), 32'h5A);
        chk("fwft:count", 32'(count2), 32'd1);
        @(posedge clk);
        #1;
        rinc2 = 1'b0;
        chk("fwft:empty_after", 32'(empty2), 32'd1);
        chk("fwft:hold", 32'(rdata2), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctrl.md
SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 4, address width; DEPTH = 2**ADDRSIZE words.
REQ-003 SHALL have parameter AFULL_THRESH, default 14, almost_full level in words, 1..DEPTH-1.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 2, almost_empty level in words, 1..DEPTH-1.
REQ-005 SHALL have parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port winc  input  1  write request.
REQ-009 SHALL have port wdata  input  DATASIZE  write data.
REQ-010 SHALL have port rinc  input  1  read request.
REQ-011 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-012 SHALL have port rdata  output  DATASIZE  read data.
REQ-013 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  ADDRSIZE+1  current fill level, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write SHALL be accepted iff winc=1 and full=0; wdata stored at wptr, wptr increments modulo DEPTH.
REQ-017 Read SHALL be accepted iff rinc=1 and empty=0; rptr increments modulo DEPTH.
REQ-018 count SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither accepted.
REQ-019 Flags SHALL derive solely from registered count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AFULL_THRESH), almost_empty = (count<=AEMPTY_THRESH).
REQ-020 At full with winc=1, rinc=1: read accepted, write rejected, count becomes DEPTH-1, overflow sets.
REQ-021 At empty with winc=1, rinc=1: write accepted, read rejected, count becomes 1, underflow sets.
REQ-022 Write accepted at edge N SHALL make empty=0 from edge N (visible cycle N+1); no bypass.
REQ-023 FWFT=0: rdata SHALL update to mem[rptr] at the edge a read is accepted (1-cycle latency) and hold otherwise.
REQ-024 FWFT=1: rdata SHALL equal mem[rptr] whenever empty=0; accepted read advances to next word next cycle; rdata value undefined-but-stable (holds last) when empty=1.
REQ-025 overflow SHALL set on any edge with winc=1 and full=1; underflow on rinc=1 and empty=1; both hold until clr_err.
REQ-026 clr_err and a new error event in the same cycle: set SHALL win.
REQ-027 Rejected requests SHALL not alter memory, pointers, count or rdata.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order strictly preserved across wrap.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) force wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rdata=0, overflow=0, underflow=0.
REQ-030 Memory array SHALL NOT be reset; contents after reset are unreachable.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; first write after rst deasserts is the first word read.
REQ-032 Requests during rst=1 SHALL be ignored.

Verification
REQ-033 Reset then write 10,15,20,25,30,35,40 (7 cycles) -> count=7, almost_empty=0, then 7 reads return 10..40 in order, empty=1 after last.
REQ-034 16 writes from empty -> almost_full=1 at count=14, full=1 at count=16; 17th write -> overflow=1, count stays 16, subsequent reads return original 16 words.
REQ-035 rinc=1 on empty -> underflow=1, rdata unchanged, count=0; clr_err pulse -> underflow=0.
REQ-036 Preload 7, then 50 cycles winc=rinc=1 with random 6-bit data -> count stays 7, read stream equals write stream delayed by 7 words, wrap exercised.
REQ-037 At full, winc=rinc=1 one cycle -> count=15, full=0, overflow=1; rst pulse mid-stream at count=9 -> all outputs per REQ-029 before next edge.
REQ-038 FWFT=1, single write of 8'hA5 -> rdata=8'hA5 the cycle empty falls, with no rinc.
